// File: rtl/img_pkg.sv
// Shared image-path definitions used by both the capture (write) and display (read) sides.
package img_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PRIME  = 2'd2,
    STREAM = 2'd3
  } state_t;

  localparam int H_PIX_DEF   = 640;
  localparam int V_LINES_DEF = 480;
  localparam int GRAY_W      = 12;
  localparam int RGB_W       = 10;

  // Keep the most significant gray bits; the low bits fall below the DAC resolution.
  function automatic logic [RGB_W-1:0] gray_to_rgb(input logic [GRAY_W-1:0] gray);
    return gray[GRAY_W-1:GRAY_W-RGB_W];
  endfunction

endpackage

// File: rtl/gray_frame_reader_pixel_counter.sv
// Raster position counter: x wraps into y, y wraps at the end of the frame.
module pixel_counter
  import img_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last, y_last;

  assign x_last = (x_q == XW'(H_PIX - 1));
  assign y_last = (y_q == YW'(V_LINES - 1));
  assign last_o = x_last & y_last;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (inc_i) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/gray_frame_reader.sv
// Drains grayscale frames from SDRAM read FIFO port 1 and streams them to the VGA
// controller as replicated 10-bit RGB, one pixel per request, with underflow tracking.
module gray_frame_reader
  import img_pkg::*;
#(
  parameter int                  H_PIX     = H_PIX_DEF,
  parameter int                  V_LINES   = V_LINES_DEF,
  parameter int                  ADDR_W    = 23,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
  parameter logic [7:0]          BURST_LEN = 8'd128,
  parameter int                  USEDW_W   = 9,
  parameter logic [USEDW_W-1:0]  PRIME_LVL = 9'd256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               frame_start,
  input  logic               pix_req,
  input  logic [15:0]        RD1_DATA,
  input  logic               rd1_empty,
  input  logic [USEDW_W-1:0] rd1_usedw,
  output logic               RD1,
  output logic [ADDR_W-1:0]  RD1_ADDR,
  output logic [ADDR_W-1:0]  RD1_MAX_ADDR,
  output logic [7:0]         RD1_LENGTH,
  output logic               RD1_LOAD,
  output logic               RD1_CLK,
  output logic [RGB_W-1:0]   oRed,
  output logic [RGB_W-1:0]   oGreen,
  output logic [RGB_W-1:0]   oBlue,
  output logic               pix_valid,
  output logic               frame_done,
  output logic               underflow,
  input  logic               clr_underflow
);

  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(H_PIX * V_LINES);

  state_t           state_q, state_d;
  logic             pix_valid_q, served_q, frame_done_q;
  logic             underflow_q, underflow_d;
  logic             count_pix, starve, rd_fire, last_pix, end_of_frame;
  logic [RGB_W-1:0] gray_rgb;
  logic             unused_hi;

  assign RD1_ADDR     = BASE_ADDR;
  assign RD1_MAX_ADDR = BASE_ADDR + FRAME_WORDS;
  assign RD1_LENGTH   = BURST_LEN;
  assign RD1_CLK      = clk;
  assign unused_hi    = ^RD1_DATA[15:GRAY_W];

  // Every request in PRIME/STREAM is counted, served or not, so line/frame geometry never slips.
  assign count_pix    = pix_req & ((state_q == PRIME) | (state_q == STREAM));
  assign starve       = pix_req & ((state_q == PRIME) | ((state_q == STREAM) & rd1_empty));
  assign rd_fire      = (state_q == STREAM) & pix_req & ~rd1_empty;
  assign end_of_frame = (state_q == STREAM) & pix_req & last_pix;

  assign RD1      = rd_fire;
  assign RD1_LOAD = (state_q == LOAD);

  pixel_counter #(
    .H_PIX   (H_PIX),
    .V_LINES (V_LINES)
  ) u_pixel_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == LOAD),
    .inc_i  (count_pix),
    .last_o (last_pix)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_start && enable) state_d = LOAD;
      LOAD:    state_d = PRIME;
      PRIME:   if (rd1_usedw >= PRIME_LVL) state_d = STREAM;
      STREAM:  if (end_of_frame) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A frame boundary while busy resynchronises; with enable low it parks the reader instead.
    if (frame_start && (state_q != IDLE)) state_d = enable ? LOAD : IDLE;
  end

  always_comb begin
    underflow_d = underflow_q;
    if (clr_underflow) underflow_d = 1'b0;
    if (starve)        underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pix_valid_q  <= 1'b0;
      served_q     <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_valid_q  <= count_pix;
      served_q     <= rd_fire;
      frame_done_q <= end_of_frame;
      underflow_q  <= underflow_d;
    end
  end

  // The FIFO word arrives registered one cycle after RD1; served_q selects it or black.
  assign gray_rgb   = served_q ? gray_to_rgb(RD1_DATA[GRAY_W-1:0]) : '0;
  assign oRed       = gray_rgb;
  assign oGreen     = gray_rgb;
  assign oBlue      = gray_rgb;
  assign pix_valid  = pix_valid_q;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;

endmodule

// File: doc/gray_frame_reader.md
Name: gray_frame_reader

Overview:
- Read-side counterpart of the grayscale capture path: drains grayscale frames previously written to SDRAM through read FIFO port 1.
- Streams pixels to the VGA controller, one per pixel request, as replicated 10-bit R/G/B.
- Owns read-port control: FIFO clear/address load per frame, priming, frame/line counting and underflow detection.

Parameters:
- H_PIX, 640, active pixels per line
- V_LINES, 480, active lines per frame
- ADDR_W, 23, SDRAM word-address width
- BASE_ADDR, 0, frame start word address
- BURST_LEN, 8'd128, RD1_LENGTH value
- PRIME_LVL, 9'd256, FIFO fill level (words) required before streaming
- USEDW_W, 9, FIFO used-words width

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  level; 0 forces IDLE at the next frame boundary
- frame_start  in  1  one-cycle pulse from VGA controller at vertical blank start
- pix_req  in  1  VGA requests one pixel this cycle
- RD1_DATA  in  16  FIFO read data; bits [11:0] = gray, [15:12] ignored
- rd1_empty  in  1  FIFO empty
- rd1_usedw  in  USEDW_W  FIFO fill level
- RD1  out  1  FIFO read request (non-show-ahead: data valid next cycle)
- RD1_ADDR  out  ADDR_W  read start address
- RD1_MAX_ADDR  out  ADDR_W  read max address
- RD1_LENGTH  out  8  burst length
- RD1_LOAD  out  1  FIFO clear / address reload
- RD1_CLK  out  1  equals clk
- oRed, oGreen, oBlue  out  10 each  pixel colour
- pix_valid  out  1  colour outputs valid
- frame_done  out  1  one-cycle pulse after last pixel of frame
- underflow  out  1  sticky underflow flag
- clr_underflow  in  1  synchronous clear of underflow

Behaviour:
- Reset: state IDLE; RD1=0, RD1_LOAD=0, pix_valid=0, frame_done=0, underflow=0, colours=0, x/y counters=0.
- Constants: RD1_ADDR=BASE_ADDR, RD1_MAX_ADDR=BASE_ADDR+H_PIX*V_LINES, RD1_LENGTH=BURST_LEN, RD1_CLK=clk.
- FSM, states IDLE, LOAD, PRIME, STREAM:
  - IDLE: frame_start & enable -> LOAD.
  - LOAD: RD1_LOAD=1 for exactly 1 cycle -> PRIME.
  - PRIME: rd1_usedw >= PRIME_LVL -> STREAM. pix_req in PRIME produces black with pix_valid, counts the pixel and sets underflow.
  - STREAM: last pixel consumed (x=H_PIX-1, y=V_LINES-1, pix_req) -> IDLE with frame_done pulse the following cycle.
- Counters: x increments on each counted pix_req, wraps to 0 at H_PIX-1 and increments y; y wraps at V_LINES-1. Both clear in LOAD.
- Pixel path, 1-cycle latency:
  - STREAM & pix_req & !rd1_empty: RD1=1 the same cycle (combinational from pix_req).
  - Next cycle: pix_valid=1 and oRed=oGreen=oBlue=RD1_DATA[11:2], registered.
- Underflow: pix_req while rd1_empty in STREAM, or pix_req in PRIME:
  - RD1 stays 0; next cycle pix_valid=1, colours=0, underflow<=1.
  - Pixel is still counted, so frame geometry is preserved.
- clr_underflow clears the flag. A new underflow in the same cycle wins (flag stays 1).
- pix_req outside PRIME/STREAM: ignored, pix_valid=0.
- frame_start while not IDLE: restart at LOAD (resync), no frame_done.
- frame_start coincident with the last pixel: last pixel served, frame_done pulses, next state LOAD.
- enable deasserted mid-frame: current frame completes, then FSM stays IDLE.
- rst_n mid-frame: immediate return to reset values. The next frame_start reloads the FIFO.

Decomposition:
- Shared package img_pkg: state_t enum (IDLE, LOAD, PRIME, STREAM), default H_PIX/V_LINES constants, GRAY_W=12, RGB_W=10. The capture-side block uses the same constants.
- Natural sub-module: pixel_counter (x/y counters with wrap and last-pixel flag), reusable by the write side.

Test Plan:
- Reset, frame_start with rd1_usedw=300, pix_req every cycle, RD1_DATA=16'h0ABC -> RD1_LOAD high 1 cycle; STREAM after 1 cycle in PRIME; pix_valid one cycle after each pix_req; colours=10'h2AF.
- H_PIX=4, V_LINES=2, 8 pix_req in STREAM -> exactly 8 RD1 pulses; frame_done single pulse one cycle after 8th request; state IDLE.
- rd1_empty=1 on 3rd pix_req -> no RD1 that cycle; colours 0 with pix_valid=1; underflow=1 until clr_underflow; later pixels normal.
- frame_start asserted mid-frame (pixel 3 of 8) -> RD1_LOAD pulse; counters reset to 0; no frame_done.
- enable=0 during frame -> frame completes with frame_done; next frame_start yields no RD1_LOAD.
- Async rst_n low mid-STREAM -> all outputs 0 immediately; IDLE until next frame_start.
